spi_slave_responder: RTL and testbench
======================================

// Module: spi_slave_responder
// PURPOSE
//  SPI responder (slave) for the platform's SPI master ports (MOSI/MISO/SCLK/SS_N). Lets a second board or
//  FPGA block be the far end of the net/ext SPI links. Mode 0 (CPOL=0, CPHA=0), MSB first.
//  SPI pins are sampled into clk_i through synchronisers. Bytes go to and from the local bus over valid/ready.
// PARAMETERS
//  DATA_WIDTH   8     bits per SPI word
//  SYNC_STAGES  2     flip-flop stages on sclk/ss_n/mosi, >=2
//  IDLE_WORD    'hFF  word shifted out when the TX buffer is empty at a load point
// PORTS
//  clk_i          in   1   system clock; all logic on its rising edge
//  rst_i          in   1   synchronous reset, active-high
//  spi_sclk_i     in   1   SPI clock from master (async to clk_i)
//  spi_ss_n_i     in   1   slave select, active-low (async)
//  spi_mosi_i     in   1   master-out data (async)
//  spi_miso_o     out  1   slave-out data
//  spi_miso_oe_o  out  1   MISO output enable (pad tri-state control)
//  tx_data_i      in   DW  word to send on the next load point
//  tx_valid_i     in   1   tx_data_i valid
//  tx_ready_o     out  1   1-entry TX buffer empty
//  rx_data_o      out  DW  last complete received word
//  rx_valid_o     out  1   rx_data_o holds an unacknowledged word
//  rx_ack_i       in   1   consumer takes rx_data_o
//  busy_o         out  1   ss_n asserted (synchronised)
//  overrun_o      out  1   1-cycle pulse: word completed while rx_valid_o=1
//  underrun_o     out  1   1-cycle pulse: IDLE_WORD loaded because TX buffer empty
// BEHAVIOUR
//  Reset values:
//   - spi_miso_o=1, spi_miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, overrun_o=0, underrun_o=0.
//   - FSM=IDLE, bit_cnt=0.
//  Sync and edge detect:
//   - sclk, ss_n and mosi each pass through SYNC_STAGES flops; one more flop is kept for edge detect.
//   - Sync is also reset; sclk/ss_n reset to 0/1.
//   - Edge events are seen SYNC_STAGES+1 clk_i cycles after the pin edge.
//   - Constraint: spi_sclk_i period >= 8 clk_i periods.
//  TX buffer:
//   - Accept when tx_valid_i & tx_ready_o; tx_ready_o drops the next cycle.
//   - Buffer is freed (tx_ready_o=1) in the cycle it is moved into the shift register.
//  FSM IDLE:
//   - oe=0, busy_o=0, sclk edges are ignored.
//   - ss_n fall event -> ACTIVE. Same cycle: load point, bit_cnt=0, oe=1, busy_o=1.
//   - spi_miso_o = MSB of the loaded word.
//  FSM ACTIVE, sclk rise:
//   - rx_sh <= {rx_sh[DW-2:0], mosi_sync}; bit_cnt++.
//   - On the DW-th rise, bit_cnt wraps to 0 and rx_data_o <= the full word.
//   - rx_valid_o=1 from the next cycle.
//   - If rx_valid_o was already 1 without ack that cycle: data is overwritten and overrun_o pulses.
//  FSM ACTIVE, sclk fall:
//   - bit_cnt!=0: tx_sh shifts left and spi_miso_o gets the next bit.
//   - bit_cnt==0 (word boundary): load point for the next word, so back-to-back words have no gap.
//  Load point:
//   - Buffer full: tx_sh <= buffer.
//   - Buffer empty: tx_sh <= IDLE_WORD and underrun_o pulses.
//  RX handshake:
//   - rx_ack_i while rx_valid_o=1 clears rx_valid_o the next cycle.
//   - A word completing in the same cycle as the ack wins: rx_valid_o stays 1, new data, no overrun.
//  ss_n rise event (any state) -> IDLE, oe=0, busy_o=0.
//   - A partial rx word (bit_cnt!=0) is discarded; rx_data_o/rx_valid_o are unchanged.
//   - A loaded tx word is lost; the TX buffer is kept.
//  ss_n rise and sclk edge in the same cycle: ss_n rise wins and the sclk edge is ignored.
//  rst_i mid-transfer: all outputs go to their reset values the next cycle; the TX buffer is emptied.
// TESTING
//  1. tx 8'hA5 pre-loaded; master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=8'h3C; rx_valid_o=1; underrun_o never pulses.
//  2. 3 back-to-back words 8'h01,02,03 with TX refilled each time -> 3 rx_valid_o/ack cycles; MISO words match the buffer order.
//  3. TX buffer empty at select -> MISO shifts 8'hFF; underrun_o one pulse.
//  4. 2 words with no rx_ack_i -> overrun_o one pulse; rx_data_o = second word.
//  5. ss_n rises after 5 sclk rises -> no rx_valid_o; next full transfer of 8'h5A is received correctly.
//  6. rst_i pulsed at bit 3 -> oe=0, tx_ready_o=1, rx_valid_o=0; new select sends IDLE_WORD.

Source files
------------

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder: receives MSB-first words from an external master and
// shifts out words supplied over a valid/ready TX buffer. SPI pins are brought
// into clk_i through synchronisers. Edges are detected on the synchronised copies.
module spi_slave_responder #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = DATA_WIDTH'('hFF)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_ss_n_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ack_i,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic                  underrun_o
);

    localparam int unsigned            CntWidth = $clog2(DATA_WIDTH);
    localparam logic [CntWidth-1:0]    LastBit  = CntWidth'(DATA_WIDTH - 1);

    typedef enum logic {
        StIdle,
        StActive
    } fsmState_e;

    fsmState_e                 state;
    logic [SYNC_STAGES-1:0]    sclkSync;
    logic [SYNC_STAGES-1:0]    ssnSync;
    logic [SYNC_STAGES-1:0]    mosiSync;
    logic                      sclkPrev;
    logic                      ssnPrev;
    logic [CntWidth-1:0]       bitCnt;
    logic [DATA_WIDTH-2:0]     rxSh;
    logic [DATA_WIDTH-2:0]     txRest;
    logic [DATA_WIDTH-1:0]     txBuf;

    logic sclkNow;
    logic ssnNow;
    logic mosiNow;
    logic sclkRise;
    logic sclkFall;
    logic ssnRise;
    logic ssnFall;
    logic loadNow;

    assign sclkNow  = sclkSync[SYNC_STAGES-1];
    assign ssnNow   = ssnSync[SYNC_STAGES-1];
    assign mosiNow  = mosiSync[SYNC_STAGES-1];
    assign sclkRise = sclkNow & ~sclkPrev;
    assign sclkFall = ~sclkNow & sclkPrev;
    assign ssnRise  = ssnNow & ~ssnPrev;
    assign ssnFall  = ~ssnNow & ssnPrev;

    // Word boundary: at select, or on an sclk fall after a completed word (deselect wins).
    assign loadNow = ((state == StIdle) && ssnFall) ||
                     ((state == StActive) && !ssnRise && sclkFall && (bitCnt == '0));

    // Pin synchronisers plus one extra stage on sclk/ss_n for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclkSync <= '0;
            ssnSync  <= '1;
            mosiSync <= '0;
            sclkPrev <= 1'b0;
            ssnPrev  <= 1'b1;
        end else begin
            sclkSync <= {sclkSync[SYNC_STAGES-2:0], spi_sclk_i};
            ssnSync  <= {ssnSync[SYNC_STAGES-2:0], spi_ss_n_i};
            mosiSync <= {mosiSync[SYNC_STAGES-2:0], spi_mosi_i};
            sclkPrev <= sclkNow;
            ssnPrev  <= ssnNow;
        end
    end

    // Transfer FSM with TX buffer, shift registers and RX handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= StIdle;
            bitCnt        <= '0;
            rxSh          <= '0;
            txRest        <= '0;
            txBuf         <= '0;
            tx_ready_o    <= 1'b1;
            spi_miso_o    <= 1'b1;
            spi_miso_oe_o <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            busy_o        <= 1'b0;
            overrun_o     <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            overrun_o  <= 1'b0;
            underrun_o <= 1'b0;

            if (rx_ack_i && rx_valid_o) begin
                rx_valid_o <= 1'b0;
            end

            if (tx_valid_i && tx_ready_o) begin
                txBuf      <= tx_data_i;
                tx_ready_o <= 1'b0;
            end

            // A full buffer at a load point is consumed; otherwise the idle word goes out.
            if (loadNow) begin
                if (!tx_ready_o) begin
                    txRest     <= txBuf[DATA_WIDTH-2:0];
                    spi_miso_o <= txBuf[DATA_WIDTH-1];
                    tx_ready_o <= 1'b1;
                end else begin
                    txRest     <= IDLE_WORD[DATA_WIDTH-2:0];
                    spi_miso_o <= IDLE_WORD[DATA_WIDTH-1];
                    underrun_o <= 1'b1;
                end
            end

            case (state)
                StIdle: begin
                    if (ssnFall) begin
                        state         <= StActive;
                        bitCnt        <= '0;
                        spi_miso_oe_o <= 1'b1;
                        busy_o        <= 1'b1;
                    end
                end
                StActive: begin
                    if (ssnRise) begin
                        state         <= StIdle;
                        bitCnt        <= '0;
                        spi_miso_oe_o <= 1'b0;
                        busy_o        <= 1'b0;
                    end else if (sclkRise) begin
                        rxSh <= {rxSh[DATA_WIDTH-3:0], mosiNow};
                        if (bitCnt == LastBit) begin
                            bitCnt     <= '0;
                            rx_data_o  <= {rxSh, mosiNow};
                            rx_valid_o <= 1'b1;
                            overrun_o  <= rx_valid_o & ~rx_ack_i;
                        end else begin
                            bitCnt <= bitCnt + CntWidth'(1);
                        end
                    end else if (sclkFall && (bitCnt != '0)) begin
                        spi_miso_o <= txRest[DATA_WIDTH-2];
                        txRest     <= {txRest[DATA_WIDTH-3:0], 1'b0};
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: an SPI master task drives the pins, a TX producer
// feeds the buffer, and a monitor acknowledges and scores received words.
module tb_spi_slave_responder;

    localparam int unsigned DW   = 8;
    localparam int unsigned H    = 6;
    localparam logic [7:0]  IDLE = 8'hFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       ssn = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       misoOe;
    logic [7:0] txData = '0;
    logic       txValid = 1'b0;
    logic       txReady;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxAck = 1'b0;
    logic       busy;
    logic       overrun;
    logic       underrun;

    int   tests = 0;
    int   failures = 0;
    int   underrunCnt = 0;
    int   overrunCnt = 0;
    bit   ackEn = 1'b1;

    logic [7:0] txWords [4];
    logic [7:0] rxWords [4];
    logic [7:0] supplyQ [$];
    logic [7:0] expMiso [$];
    logic [7:0] expRx [$];

    spi_slave_responder #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2),
        .IDLE_WORD  (8'hFF)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .spi_sclk_i   (sclk),
        .spi_ss_n_i   (ssn),
        .spi_mosi_i   (mosi),
        .spi_miso_o   (miso),
        .spi_miso_oe_o(misoOe),
        .tx_data_i    (txData),
        .tx_valid_i   (txValid),
        .tx_ready_o   (txReady),
        .rx_data_o    (rxData),
        .rx_valid_o   (rxValid),
        .rx_ack_i     (rxAck),
        .busy_o       (busy),
        .overrun_o    (overrun),
        .underrun_o   (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Count single-cycle status pulses.
    always @(negedge clk) begin
        if (underrun) underrunCnt++;
        if (overrun) overrunCnt++;
    end

    // TX producer: offers queued words whenever the buffer is empty.
    initial begin
        forever begin
            @(negedge clk);
            if (supplyQ.size() > 0 && txReady && !rst) begin
                txData  = supplyQ.pop_front();
                txValid = 1'b1;
                @(negedge clk);
                txValid = 1'b0;
            end
        end
    end

    // RX monitor: acknowledges each presented word and scores it against the model.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rxAck) begin
                rxAck = 1'b0;
            end else if (ackEn && rxValid) begin
                if (expRx.size() == 0) begin
                    tests++;
                    failures++;
                    $display("FAIL rx_unexpected: got %0h expected no word", rxData);
                end else begin
                    e = expRx.pop_front();
                    check("rx_word", 32'(rxData), 32'(e));
                end
                rxAck = 1'b1;
            end
        end
    end

    // One select session: n full words (or a partial word of pBits when n==0), k TX words supplied.
    task automatic runSession(input int n, input int pBits, input bit trailing, input int k);
        int         loads;
        int         u0;
        int         o0;
        int         nLoop;
        int         nb;
        logic [7:0] cap;
        logic [7:0] w;
        bit         last;

        for (int i = 0; i < k; i++) supplyQ.push_back(txWords[i]);
        loads = (n == 0) ? 1 : n + int'(trailing);
        for (int i = 0; i < n; i++) expMiso.push_back((i < k) ? txWords[i] : IDLE);
        if (n > 0) begin
            if (ackEn) for (int i = 0; i < n; i++) expRx.push_back(rxWords[i]);
            else expRx.push_back(rxWords[n-1]);
        end
        u0 = underrunCnt;
        o0 = overrunCnt;

        repeat (4) @(negedge clk);
        ssn = 1'b0;
        repeat (H) @(negedge clk);
        nLoop = (n == 0) ? 1 : n;
        nb    = (n == 0) ? pBits : int'(DW);
        for (int wi = 0; wi < nLoop; wi++) begin
            cap = '0;
            w   = rxWords[wi];
            for (int b = 0; b < nb; b++) begin
                mosi = w[7-b];
                repeat (H) @(negedge clk);
                if (b == 0) begin
                    check("miso_oe", 32'(misoOe), 32'd1);
                    check("busy", 32'(busy), 32'd1);
                end
                cap  = {cap[6:0], miso};
                sclk = 1'b1;
                repeat (H) @(negedge clk);
                sclk = 1'b0;
                last = (wi == nLoop - 1) && (b == nb - 1);
                if (last && !trailing) ssn = 1'b1;
                repeat (H) @(negedge clk);
            end
            if (n > 0) begin
                if (expMiso.size() == 0) check("miso_queue", 32'(expMiso.size()), 32'd1);
                else check("miso_word", 32'(cap), 32'(expMiso.pop_front()));
            end
        end
        if (trailing) ssn = 1'b1;
        repeat (4 * H) @(negedge clk);

        check("underrun_count", 32'(underrunCnt - u0), 32'((loads > k) ? loads - k : 0));
        check("overrun_count", 32'(overrunCnt - o0), 32'((!ackEn && n > 1) ? n - 1 : 0));
        check("idle_oe", 32'(misoOe), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        if (ackEn) check("rx_drained", 32'(expRx.size()), 32'd0);
    endtask

    initial begin
        int u0;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd1);
        check("rst_oe", 32'(misoOe), 32'd0);
        check("rst_tx_ready", 32'(txReady), 32'd1);
        check("rst_rx_data", 32'(rxData), 32'd0);
        check("rst_rx_valid", 32'(rxValid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single word with pre-loaded TX
        txWords[0] = 8'hA5;
        rxWords[0] = 8'h3C;
        runSession(1, 0, 1'b0, 1);
        check("rx_data_t1", 32'(rxData), 32'h3C);

        // 2: three back-to-back words with refills
        txWords[0] = 8'hC1; txWords[1] = 8'hC2; txWords[2] = 8'hC3;
        rxWords[0] = 8'h01; rxWords[1] = 8'h02; rxWords[2] = 8'h03;
        runSession(3, 0, 1'b0, 3);

        // 3: empty TX buffer at select
        rxWords[0] = 8'h96;
        runSession(1, 0, 1'b0, 0);

        // 4: two words without acknowledge
        ackEn = 1'b0;
        txWords[0] = 8'h11; txWords[1] = 8'h22;
        rxWords[0] = 8'h4B; rxWords[1] = 8'hD2;
        runSession(2, 0, 1'b0, 2);
        check("rx_valid_held", 32'(rxValid), 32'd1);
        check("rx_data_t4", 32'(rxData), 32'hD2);
        ackEn = 1'b1;
        repeat (10) @(negedge clk);
        check("rx_drained_t4", 32'(expRx.size()), 32'd0);

        // 5: partial word aborted, then full word
        txWords[0] = 8'h77;
        rxWords[0] = 8'hE7;
        runSession(0, 5, 1'b0, 1);
        check("rx_valid_partial", 32'(rxValid), 32'd0);
        rxWords[0] = 8'h5A;
        runSession(1, 0, 1'b0, 0);
        check("rx_data_t5", 32'(rxData), 32'h5A);

        // 6: reset in the middle of a word
        supplyQ.push_back(8'h81);
        supplyQ.push_back(8'h42);
        repeat (4) @(negedge clk);
        u0 = underrunCnt;
        ssn = 1'b0;
        repeat (H) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            mosi = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
            repeat (H) @(negedge clk);
        end
        check("pre_rst_tx_ready", 32'(txReady), 32'd0);
        ssn = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_oe", 32'(misoOe), 32'd0);
        check("mid_rst_tx_ready", 32'(txReady), 32'd1);
        check("mid_rst_rx_valid", 32'(rxValid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_underrun", 32'(underrunCnt - u0), 32'd0);
        repeat (10) @(negedge clk);
        rxWords[0] = 8'h69;
        runSession(1, 0, 1'b0, 0);

        // Randomised sessions
        for (int r = 0; r < 8; r++) begin
            int n;
            int k;
            n = int'($urandom_range(1, 3));
            k = int'($urandom_range(0, n));
            for (int i = 0; i < 4; i++) begin
                txWords[i] = 8'($urandom);
                rxWords[i] = 8'($urandom);
            end
            runSession(n, 0, 1'($urandom_range(0, 1)), k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
